// File: rtl/pdatapath_pkg.sv
// Shared types for the self-sequenced datapath: ALU op codes, command kinds,
// FSM state encoding and a width helper.
package pdatapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_RSV} cmd_kind_e;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_RESP} state_e;

  localparam int PERF_W = 32;

  // Address width for n entries, never below 1 so a 2-entry file still gets a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pdatapath_if.sv
// Command / response handshake bundle between a command source and pdatapath_seq.
interface pdatapath_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [2:0]        cmd_op;
  logic [RA_W-1:0]   cmd_rs;
  logic [RA_W-1:0]   cmd_rt;
  logic [RA_W-1:0]   cmd_rd;
  logic [DATA_W-1:0] cmd_imm;
  logic              cmd_src1_zero;
  logic              cmd_src2_imm;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W:0]   rsp_data;
  logic              rsp_zero;
  logic              busy;

  modport master (
    output cmd_valid, cmd_kind, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
           cmd_src1_zero, cmd_src2_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, busy
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
           cmd_src1_zero, cmd_src2_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/pdp_alu.sv
// Combinational W-bit ALU; ovf is signed overflow for ADD/SUB only.
module pdp_alu
  import pdatapath_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] f,
  output logic         ovf,
  output logic         zero
);
  logic [W-1:0] sum, dif;
  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    f   = '0;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        f   = sum;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        f   = dif;
        ovf = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      OP_AND:   f = a & b;
      OP_OR:    f = a | b;
      OP_XOR:   f = a ^ b;
      OP_NOR:   f = ~(a | b);
      OP_SLT:   f = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASSB: f = b;
    endcase
  end

  assign zero = (f == '0);
endmodule

// File: rtl/pdatapath_seq.sv
// Self-sequenced datapath: ALU + register file (r0 = 0) + sync data memory under a
// one-command-at-a-time FSM. Optional PDATAPATH_PERF_CNT_EN adds perf counters.
module pdatapath_seq
  import pdatapath_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NREG      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_general,
  pdatapath_if.slave        bus
`ifdef PDATAPATH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_cmds,
  output logic [PERF_W-1:0] perf_stall
`endif
);
  localparam int RA_W = clog2(NREG);
  localparam int MA_W = clog2(MEM_DEPTH);

  state_e            state;
  cmd_kind_e         kind_q;
  alu_op_e           op_q;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, res_q;
  logic              s1z_q, s2i_q, ovf_q, zero_q;
  logic [DATA_W:0]   st_q, mem_q, rsp_data_q;
  logic              cmd_ready_q, rsp_valid_q, rsp_zero_q;
  logic [DATA_W:0]   rf  [NREG];
  logic [DATA_W:0]   mem [MEM_DEPTH];

  logic [DATA_W-1:0] alu_a, alu_b, alu_f;
  logic              alu_ovf, alu_zero, accept;
  logic [MA_W-1:0]   maddr;

  assign accept = bus.cmd_valid && cmd_ready_q;
  assign alu_a  = s1z_q ? '0 : a_q;
  assign alu_b  = s2i_q ? imm_q : b_q;
  assign maddr  = res_q[MA_W-1:0];

  pdp_alu #(.W(DATA_W)) u_alu (
    .a(alu_a), .b(alu_b), .op(op_q), .f(alu_f), .ovf(alu_ovf), .zero(alu_zero)
  );

  // Memory is deliberately not reset; read port is registered every cycle so the
  // word addressed during MEM is ready in WB.
  always_ff @(posedge clk) begin
    if (state == S_MEM && kind_q == K_STORE) mem[maddr] <= st_q;
    mem_q <= mem[maddr];
  end

  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      kind_q      <= K_ALU;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      st_q        <= '0;
      s1z_q       <= 1'b0;
      s2i_q       <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          kind_q      <= cmd_kind_e'(bus.cmd_kind);
          op_q        <= alu_op_e'(bus.cmd_op);
          rd_q        <= bus.cmd_rd;
          imm_q       <= bus.cmd_imm;
          s1z_q       <= bus.cmd_src1_zero;
          s2i_q       <= bus.cmd_src2_imm;
          a_q         <= rf[bus.cmd_rs][DATA_W-1:0];
          b_q         <= rf[bus.cmd_rt][DATA_W-1:0];
          st_q        <= rf[bus.cmd_rt];
          cmd_ready_q <= 1'b0;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_f;
          ovf_q  <= alu_ovf;
          zero_q <= alu_zero;
          state  <= (kind_q == K_LOAD || kind_q == K_STORE) ? S_MEM : S_WB;
        end
        S_MEM: state <= S_WB;
        S_WB: begin
          // r0 is never written, so it reads as zero forever.
          if (rd_q != '0) begin
            if (kind_q == K_ALU)       rf[rd_q] <= {ovf_q, res_q};
            else if (kind_q == K_LOAD) rf[rd_q] <= mem_q;
          end
          if (kind_q == K_LOAD)       rsp_data_q <= mem_q;
          else if (kind_q == K_STORE) rsp_data_q <= st_q;
          else                        rsp_data_q <= {ovf_q, res_q};
          rsp_zero_q  <= zero_q;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = ~cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

`ifdef PDATAPATH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) begin
      perf_cmds  <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && perf_cmds != '1) perf_cmds <= perf_cmds + 1'b1;
      if (state == S_RESP && !bus.rsp_ready && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: doc/pdatapath_seq.md
Name: pdatapath_seq

Overview:
Parametrised, self-sequenced successor to the VIO-driven 8-bit datapath. It contains a parametrised ALU, an NREG-entry register file with r0 hard-wired to zero, and a synchronous data memory. An internal FSM replaces manual VIO stepping: one command is accepted over a valid/ready handshake, executed as ALU, LOAD or STORE, and answered on a valid/ready response channel. It sits between a command source (VIO, UART bridge or future fetch unit) and the top level.

Parameters:
DATA_W, 8, ALU/memory data width; register and memory entries are DATA_W+1 bits (MSB holds ovf)
NREG, 4, register count; power of two, >=2; RA_W = clog2(NREG)
MEM_DEPTH, 256, data memory words; power of two; MA_W = clog2(MEM_DEPTH), MA_W <= DATA_W

Ports:
clk  in  1  clock
rst_general  in  1  reset; asynchronous, active-low (low = in reset)
cmd_valid  in  1  command offered
cmd_ready  out  1  FSM in IDLE
cmd_kind  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved (executed as ALU, no writeback)
cmd_op  in  3  ALU op
cmd_rs / cmd_rt / cmd_rd  in  RA_W each  source1 / source2 / destination register
cmd_imm  in  DATA_W  immediate
cmd_src1_zero  in  1  ALU a = 0 instead of rs
cmd_src2_imm  in  1  ALU b = imm instead of rt
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_data  out  DATA_W+1  {ovf, result}, or loaded word, or stored word
rsp_zero  out  1  ALU result == 0
busy  out  1  ~cmd_ready

Behaviour:
- Reset (rst_general low, async): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0; all registers cleared. Memory contents are not reset.
- One clock; reset is asynchronous and active-low.
- ALU ops (DATA_W bits): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT (signed, result 0/1), 111 PASSB.
- ovf is signed overflow for ADD/SUB and 0 for all other ops. rsp_zero = (result == 0).
- FSM states: IDLE -> EXEC -> [MEM] -> WB -> RESP -> IDLE.
  - IDLE: on cmd_valid&&cmd_ready, latch all cmd fields and read rs/rt data (low DATA_W bits) at the accept edge.
  - EXEC: compute ALU result and flags into registers.
  - MEM: LOAD/STORE only. Address = result[MA_W-1:0]; wraps modulo MEM_DEPTH. STORE writes the full DATA_W+1-bit rt word. LOAD read latency is 1 cycle; data is captured at the end of MEM.
  - WB: ALU writes {ovf,result} to rd; LOAD writes the memory word to rd; STORE/reserved write nothing. Writes to r0 are dropped.
  - RESP: rsp_valid=1; rsp_data and rsp_zero held stable until rsp_ready. Leave on rsp_valid&&rsp_ready.
- Latency from accept edge to rsp_valid: ALU 3 cycles, LOAD/STORE 4 cycles. Minimum issue interval is latency+1.
- No hazards: writeback completes before the next accept, so a back-to-back command reads the new value.
- cmd_valid during busy is ignored. Commands are not queued.
- rsp_valid never drops without rsp_ready. Reset mid-operation aborts it; a partially issued store may not occur.

Optional Feature:
PDATAPATH_PERF_CNT_EN
- Defined: adds outputs perf_cmds[31:0] and perf_stall[31:0], both reset to 0 and saturating at all-ones.
  - perf_cmds counts accepted commands.
  - perf_stall counts cycles in RESP with rsp_ready=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package pdatapath_pkg: ALU op codes, cmd_kind codes, FSM state enum, clog2-derived width helpers.
- Natural sub-module: pdp_alu (DATA_W parametrised combinational ALU producing f, ovf, zero).
- Register file and memory stay inline, or reuse the existing reg_file generalised.

Test Plan (DATA_W=8, NREG=4, MEM_DEPTH=256):
1. Reset, then ALU ADD src1_zero=1 src2_imm=1 imm=0x05 rd=1 -> rsp_valid 3 cycles after accept; rsp_data=9'h005, zero=0. Then ADD rs=1 rt=1 rd=2 -> 9'h00A.
2. r1=0x7F; ADD rs=1 imm=0x01 rd=3 -> rsp_data=9'h180 (ovf=1); SUB rs=1 rt=1 -> 9'h000, rsp_zero=1.
3. STORE rt=2 addr imm 0x10 (src1_zero, ADD) -> rsp_data=9'h00A. LOAD rd=3 addr 0x10 -> rsp_data=9'h00A, r3=0x00A. ADD rs=1(0x05)+imm 0xFF addressing -> memory address 0x04 (wrap).
4. ALU result to rd=0 -> rsp_data correct; subsequent read of r0 as rs returns 0.
5. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, offered cmd ignored. With PDATAPATH_PERF_CNT_EN defined -> perf_stall=5.
6. Assert rst_general low mid-EXEC -> cmd_ready=1, rsp_valid=0 immediately (async); all registers read 0 afterwards.
